// File: rtl/button_updown_counter.sv
// -----------------------------------------------------------------------------
// button_updown_counter
//
// Purpose:
//   Two raw, bouncing, active-low pushbuttons drive a 4-bit modulo-16 counter.
//   Each button is synchronized (2 flops) and debounced by its own FSM
//   (IDLE -> CHK_PRESS -> HELD -> CHK_REL). One accepted press is one event.
//   An up event adds 1 and a down event subtracts 1. Events on both buttons
//   in the same cycle cancel. The count is shown inverted on active-low LEDs.
//
// Configuration:
//   AUTO_REPEAT_EN - when defined, a button held in HELD for RPT_DELAY cycles
//                    emits a repeat event, then one every RPT_PERIOD cycles.
//                    When undefined, no repeat hardware is built.
//
// Parameters:
//   DEB_CYCLES  - cycles a level must be stable before it is accepted
//   RPT_DELAY   - held cycles before the first auto-repeat event
//   RPT_PERIOD  - cycles between later auto-repeat events
//
// Ports:
//   CLK     in   kit clock, rising edge
//   RST     in   asynchronous active-high reset
//   BTN_UP  in   raw count-up button, active low
//   BTN_DN  in   raw count-down button, active low
//   LED     out  [3:0] ~count, for active-low LEDs
//   EVT     out  one-cycle pulse in the cycle the count register changed
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// button_debounce_fsm
//
// Purpose:
//   Synchronizer plus debounce FSM for one active-low button. evt_o is a
//   combinational one-cycle pulse, high in the cycle before the FSM enters
//   HELD (and, with AUTO_REPEAT_EN, on each repeat tick while held).
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   asynchronous active-high reset
//   btn_n_i   in   raw active-low button
//   evt_o     out  press / repeat event pulse
// -----------------------------------------------------------------------------
module button_debounce_fsm #(
    parameter int unsigned DEB_CYCLES = 2000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int unsigned RPT_DELAY  = 100000,
    parameter int unsigned RPT_PERIOD = 25000
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic evt_o
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        HELD,
        CHK_REL
    } state_t;

    logic [1:0]    sync_q;
    logic          btn_s;
    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Synchronizer flops reset to 1 so a reset looks like a released button.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], btn_n_i};
        end
    end

    assign btn_s = sync_q[1];

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    logic [RW-1:0] rpt_q, rpt_d;
    // Set once the initial RPT_DELAY has elapsed; later ticks use RPT_PERIOD.
    logic          rpt_armed_q, rpt_armed_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_o   = 1'b0;
`ifdef AUTO_REPEAT_EN
        // Repeat timer is cleared on every cycle not spent held in HELD,
        // so it restarts from zero on each entry to HELD.
        rpt_d       = '0;
        rpt_armed_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!btn_s) begin
                    state_d = CHK_PRESS;
                end
            end

            CHK_PRESS: begin
                if (btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    evt_o   = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end

            HELD: begin
                if (btn_s) begin
                    state_d = CHK_REL;
                    cnt_d   = '0;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (!rpt_armed_q) begin
                        if (rpt_q == RW'(RPT_DELAY - 1)) begin
                            evt_o       = 1'b1;
                            rpt_d       = '0;
                            rpt_armed_d = 1'b1;
                        end else begin
                            rpt_d       = rpt_q + RW'(1);
                            rpt_armed_d = 1'b0;
                        end
                    end else begin
                        rpt_armed_d = 1'b1;
                        if (rpt_q == RW'(RPT_PERIOD - 1)) begin
                            evt_o = 1'b1;
                            rpt_d = '0;
                        end else begin
                            rpt_d = rpt_q + RW'(1);
                        end
                    end
`endif
                end
            end

            CHK_REL: begin
                if (!btn_s) begin
                    // Release bounce: back to HELD, no new event.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

module button_updown_counter #(
    parameter int unsigned DEB_CYCLES = 2000,
    parameter int unsigned RPT_DELAY  = 100000,
    parameter int unsigned RPT_PERIOD = 25000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_UP,
    input  logic       BTN_DN,
    output logic [3:0] LED,
    output logic       EVT
);

    // Reject nonsensical timing parameters at elaboration.
    if (DEB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_params
        $error("button_updown_counter: timing parameters must be >= 1");
    end

    logic       up_evt;
    logic       dn_evt;
    logic [3:0] count_q, count_d;
    logic       evt_q, evt_d;

`ifdef AUTO_REPEAT_EN
    button_debounce_fsm #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) u_deb_up (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (BTN_UP),
        .evt_o   (up_evt)
    );

    button_debounce_fsm #(
        .DEB_CYCLES (DEB_CYCLES),
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) u_deb_dn (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (BTN_DN),
        .evt_o   (dn_evt)
    );
`else
    button_debounce_fsm #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (BTN_UP),
        .evt_o   (up_evt)
    );

    button_debounce_fsm #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_dn (
        .clk_i   (CLK),
        .rst_i   (RST),
        .btn_n_i (BTN_DN),
        .evt_o   (dn_evt)
    );
`endif

    // Exactly one event changes the count; simultaneous events cancel.
    always_comb begin
        count_d = count_q;
        evt_d   = 1'b0;
        if (up_evt && !dn_evt) begin
            count_d = count_q + 4'd1;
            evt_d   = 1'b1;
        end else if (dn_evt && !up_evt) begin
            count_d = count_q - 4'd1;
            evt_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            evt_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            evt_q   <= evt_d;
        end
    end

    assign LED = ~count_q;
    assign EVT = evt_q;

endmodule

// File: tb/tb_button_updown_counter.sv
module tb_button_updown_counter;

    logic       CLK;
    logic       RST;
    logic       BTN_UP;
    logic       BTN_DN;
    logic [3:0] LED;
    logic       EVT;

    int checks   = 0;
    int failures = 0;
    int evt_cnt  = 0;
    int ev0;

    button_updown_counter #(
        .DEB_CYCLES (8),
        .RPT_DELAY  (40),
        .RPT_PERIOD (10)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_UP (BTN_UP),
        .BTN_DN (BTN_DN),
        .LED    (LED),
        .EVT    (EVT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // EVT pulses counted mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (EVT === 1'b1) evt_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_up();
        BTN_UP = 1'b0;
        tick(20);
        BTN_UP = 1'b1;
        tick(20);
    endtask

    task automatic press_dn();
        BTN_DN = 1'b0;
        tick(20);
        BTN_DN = 1'b1;
        tick(20);
    endtask

    initial begin
        RST    = 1'b1;
        BTN_UP = 1'b1;
        BTN_DN = 1'b1;
        tick(3);
        chk("reset_led", 32'(LED), 32'hF);
        chk("reset_evt", 32'(EVT), 32'h0);
        RST = 1'b0;

        // Idle after reset
        ev0 = evt_cnt;
        tick(100);
        chk("idle_led", 32'(LED), 32'hF);
        chk("idle_evt_count", 32'(evt_cnt - ev0), 32'd0);

        // Bouncing press: 5 short lows of 3 cycles each
        ev0 = evt_cnt;
        for (int i = 0; i < 5; i++) begin
            BTN_UP = 1'b0;
            tick(3);
            BTN_UP = 1'b1;
            tick(3);
        end
        chk("bounce_no_evt", 32'(evt_cnt - ev0), 32'd0);
        chk("bounce_led", 32'(LED), 32'hF);
        // Stable press: LED changes on the 11th edge (2 sync + 8 + 1)
        BTN_UP = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk("latency_before", 32'(LED), 32'hF);
        @(posedge CLK);
        @(negedge CLK);
        chk("latency_led", 32'(LED), 32'hE);
        chk("latency_evt_hi", 32'(EVT), 32'h1);
        @(negedge CLK);
        chk("evt_one_cycle", 32'(EVT), 32'h0);
        tick(20);
        BTN_UP = 1'b1;
        tick(30);
        chk("bounce_press_evts", 32'(evt_cnt - ev0), 32'd1);
        chk("bounce_press_led", 32'(LED), 32'hE);

        // Count 1 -> 15 with 14 presses
        ev0 = evt_cnt;
        for (int i = 0; i < 14; i++) press_up();
        chk("up14_evts", 32'(evt_cnt - ev0), 32'd14);
        chk("count15_led", 32'(LED), 32'h0);

        // Wrap 15 -> 0 and 0 -> 15
        press_up();
        chk("wrap_up_led", 32'(LED), 32'hF);
        press_dn();
        chk("wrap_dn_led", 32'(LED), 32'h0);
        press_dn();
        chk("dn_14_led", 32'(LED), 32'h1);
        press_up();
        chk("up_15_led", 32'(LED), 32'h0);

        // Both buttons together: events cancel
        ev0 = evt_cnt;
        BTN_UP = 1'b0;
        BTN_DN = 1'b0;
        tick(20);
        BTN_UP = 1'b1;
        BTN_DN = 1'b1;
        tick(30);
        chk("both_no_evt", 32'(evt_cnt - ev0), 32'd0);
        chk("both_led", 32'(LED), 32'h0);

        // Reset mid-debounce with BTN_UP held
        BTN_UP = 1'b0;
        tick(6);
        RST = 1'b1;
        #1;
        chk("async_reset_led", 32'(LED), 32'hF);
        tick(3);
        chk("reset_hold_evt", 32'(EVT), 32'h0);
        chk("reset_hold_led", 32'(LED), 32'hF);
        RST = 1'b0;
        ev0 = evt_cnt;
        tick(30);
        chk("rst_redebounce_evts", 32'(evt_cnt - ev0), 32'd1);
        chk("rst_redebounce_led", 32'(LED), 32'hE);
        BTN_UP = 1'b1;
        tick(30);
        chk("rst_release_evts", 32'(evt_cnt - ev0), 32'd1);

        // Long hold from count 0
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(5);
        chk("hold_start_led", 32'(LED), 32'hF);
        ev0 = evt_cnt;
        BTN_UP = 1'b0;
        tick(11);
        chk("hold_first_led", 32'(LED), 32'hE);
        tick(80);
        BTN_UP = 1'b1;
        tick(30);
`ifdef AUTO_REPEAT_EN
        chk("hold_evts", 32'(evt_cnt - ev0), 32'd6);
        chk("hold_led", 32'(LED), 32'h9);
`else
        chk("hold_evts", 32'(evt_cnt - ev0), 32'd1);
        chk("hold_led", 32'(LED), 32'hE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
